sar_ctrl: RTL and testbench
===========================

# sar_ctrl

Successive-approximation (SAR) conversion controller for the comparator/DAC datapath. On a start request it runs a track/hold phase, then a binary search from MSB to LSB. Each step drives a trial code to the DAC, waits for settling and samples the comparator. The DAC is driven both as a binary code and as a thermometer vector, since the analog front end uses a unary capacitor array. The block returns the converted code with a one-cycle `done` pulse.

## Interface
- `WIDTH`, 4: resolution in bits; thermometer width is 2^WIDTH-1.
- `SAMPLE_CYCLES`, 2: cycles `sample` is held high; must be ≥1.
- `SETTLE_CYCLES`, 1: DAC settling cycles before each compare; 0 is legal and means no settle phase.
- `clk`  in  1  clock. One clock; all state changes on its rising edge.
- `rst`  in  1  reset. Synchronous and active-high.
- `start`  in  1  conversion request; accepted only in IDLE.
- `abort`  in  1  cancels an in-progress conversion.
- `comp_in`  in  1  comparator output; 1 means vin ≥ DAC level.
- `sample`  out  1  track/hold control; 1 means track.
- `dac_code`  out  WIDTH  current trial code, registered.
- `dac_therm`  out  2^WIDTH-1  thermometer encoding of `dac_code`; bit k = (dac_code > k).
- `busy`  out  1  high in SAMPLE, SETTLE and COMPARE.
- `done`  out  1  one-cycle pulse when `result` is updated.
- `result`  out  WIDTH  last completed conversion; held until the next completion.

## Operation
- Reset values:
  - state = IDLE.
  - `sample`=0, `dac_code`=0, `dac_therm`=0.
  - `busy`=0, `done`=0, `result`=0.
  - Internal bit index = WIDTH-1.
- States and transitions:
  - IDLE: `start`=1 → SAMPLE. Set `sample`=1, `dac_code`=0, bit index = WIDTH-1.
  - SAMPLE: lasts SAMPLE_CYCLES cycles. On exit, `sample`=0 and `dac_code` = 1<<(WIDTH-1). Go to SETTLE, or straight to COMPARE if SETTLE_CYCLES=0.
  - SETTLE: lasts SETTLE_CYCLES cycles, then → COMPARE.
  - COMPARE (1 cycle): `comp_in` is sampled at the closing edge. If `comp_in`=0, clear the bit under test.
    - If bit index > 0: decrement the index, set the next lower bit in `dac_code`, go to SETTLE (or COMPARE if SETTLE_CYCLES=0).
    - If bit index = 0: `result` gets the final code, then → DONE.
  - DONE (1 cycle): `done`=1, `busy`=0, `dac_code` holds the final code, then → IDLE.
- `abort`=1 in SAMPLE, SETTLE or COMPARE → IDLE at the next edge.
  - `sample`=0, `dac_code`=0, no `done` pulse, `result` unchanged.
  - `abort` has priority over a COMPARE completion in the same cycle.
- `start` outside IDLE is ignored, including in the DONE cycle; it is not queued.
- `abort` in IDLE or DONE is ignored.
- `rst` has priority over everything and forces reset values at the next edge, including mid-conversion.
- `dac_therm` is a pure combinational function of registered `dac_code`.

## Timing
- The edge where IDLE sees `start`=1 is edge 0. `busy` and `sample` are high from cycle 1.
- Conversion length: 1 + SAMPLE_CYCLES + WIDTH·(SETTLE_CYCLES+1) cycles to the `done` pulse.
- With defaults (WIDTH=4, SAMPLE_CYCLES=2, SETTLE_CYCLES=1):
  - Cycles 1–2: SAMPLE.
  - Cycles 3–4, 5–6, 7–8, 9–10: bits 3, 2, 1, 0, each as SETTLE then COMPARE.
  - Cycle 11: DONE, `done`=1, `result` valid.
  - Cycle 12: IDLE. The earliest new `start` can be accepted at the end of cycle 12.
- `comp_in` must be stable during the COMPARE cycle; it is not used in any other cycle.

## Structure
- Shared package `sar_pkg`:
  - State enum: IDLE, SAMPLE, SETTLE, COMPARE, DONE.
  - Default WIDTH.
  - Function giving the thermometer width, 2^WIDTH-1.
- Sub-module `bin2therm`: parameterised binary-to-thermometer encoder, instantiated on `dac_code`. It is the inverse of the team's existing thermometer-to-binary decoder, and both share the same bit convention (LSB-first fill).
- One FSM with a settle/sample down-counter and a bit-index register.

## Test plan
- `comp_in` tied to 1, start pulse → trial codes 8,12,14,15; `result`=4'b1111; `done` in cycle 11; `dac_therm` = all ones in DONE.
- `comp_in` tied to 0 → trial codes 8,4,2,1; `result`=4'b0000.
- Behavioural vin=10, `comp_in` = (10 ≥ dac_code) → trial codes 8,12,10,11; `result`=4'b1010; `dac_therm`=15'b000001111111111 while `dac_code`=10.
- `abort` asserted in cycle 6 of a conversion → IDLE at cycle 7, no `done` pulse, `result` retains its previous value; a fresh start then converts normally.
- `start` held high continuously → conversions are back-to-back with exactly one IDLE cycle between `done` and the next SAMPLE; `start` during busy has no effect.
- `rst` asserted in cycle 5 → all outputs at reset values next cycle. Repeat with SETTLE_CYCLES=0 and check `done` arrives in cycle 7.

Source files
------------

// File: rtl/sar_pkg.sv
// Shared types and helpers for the SAR conversion controller.
package sar_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SAMPLE,
        SETTLE,
        COMPARE,
        DONE
    } sar_state_e;

    localparam int DEF_WIDTH = 4;

    function automatic int therm_w(input int w);
        return (1 << w) - 1;
    endfunction

endpackage

// File: rtl/sar_ctrl_bin2therm.sv
// Binary-to-thermometer encoder, LSB-first fill: therm_o[k] = (bin_i > k).
module bin2therm
    import sar_pkg::*;
#(
    parameter int BIN_W = DEF_WIDTH
) (
    input  logic [BIN_W-1:0]          bin_i,
    output logic [therm_w(BIN_W)-1:0] therm_o
);

    always_comb begin
        therm_o = '0;
        for (int k = 0; k < therm_w(BIN_W); k++) begin
            therm_o[k] = (int'(bin_i) > k);
        end
    end

endmodule

// File: rtl/sar_ctrl.sv
// SAR conversion controller: track/hold, then MSB-first binary search driving
// the DAC as binary and thermometer code; result returned with a done pulse.
module sar_ctrl
    import sar_pkg::*;
#(
    parameter int WIDTH         = DEF_WIDTH,
    parameter int SAMPLE_CYCLES = 2,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      abort,
    input  logic                      comp_in,
    output logic                      sample,
    output logic [WIDTH-1:0]          dac_code,
    output logic [therm_w(WIDTH)-1:0] dac_therm,
    output logic                      busy,
    output logic                      done,
    output logic [WIDTH-1:0]          result
);

    localparam int CNT_MAX = (SAMPLE_CYCLES > SETTLE_CYCLES) ? SAMPLE_CYCLES : SETTLE_CYCLES;
    localparam int CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);
    localparam int IDX_W   = (WIDTH < 2) ? 1 : $clog2(WIDTH);

    localparam logic [CNT_W-1:0] SAMPLE_LOAD = CNT_W'(SAMPLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
    localparam logic [IDX_W-1:0] IDX_TOP     = IDX_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MSB_CODE    = WIDTH'(1 << (WIDTH - 1));
    localparam sar_state_e       TEST_STATE  = (SETTLE_CYCLES == 0) ? COMPARE : SETTLE;

    sar_state_e       state_q;
    logic             sample_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] code_q;
    logic [WIDTH-1:0] result_q;
    logic [IDX_W-1:0] idx_q;
    logic [CNT_W-1:0] cnt_q;

    logic [WIDTH-1:0] bit_sel;
    logic [WIDTH-1:0] next_sel;
    logic [WIDTH-1:0] code_kept_d;

    // Bit under test, the next lower trial bit, and the code after this compare.
    always_comb begin
        bit_sel  = '0;
        next_sel = '0;
        for (int k = 0; k < WIDTH; k++) begin
            if (k == int'(idx_q))     bit_sel[k]  = 1'b1;
            if (k + 1 == int'(idx_q)) next_sel[k] = 1'b1;
        end
        code_kept_d = comp_in ? code_q : (code_q & ~bit_sel);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            sample_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            code_q   <= '0;
            result_q <= '0;
            idx_q    <= IDX_TOP;
            cnt_q    <= '0;
        end else begin
            done_q <= 1'b0;
            // busy_q is high exactly in the abortable states
            if (abort && busy_q) begin
                state_q  <= IDLE;
                sample_q <= 1'b0;
                busy_q   <= 1'b0;
                code_q   <= '0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (start) begin
                            state_q  <= SAMPLE;
                            sample_q <= 1'b1;
                            busy_q   <= 1'b1;
                            code_q   <= '0;
                            idx_q    <= IDX_TOP;
                            cnt_q    <= SAMPLE_LOAD;
                        end
                    end
                    SAMPLE: begin
                        if (cnt_q == '0) begin
                            sample_q <= 1'b0;
                            code_q   <= MSB_CODE;
                            state_q  <= TEST_STATE;
                            cnt_q    <= SETTLE_LOAD;
                        end else begin
                            cnt_q <= cnt_q - 1'b1;
                        end
                    end
                    SETTLE: begin
                        if (cnt_q == '0) state_q <= COMPARE;
                        else             cnt_q   <= cnt_q - 1'b1;
                    end
                    COMPARE: begin
                        if (idx_q != '0) begin
                            code_q  <= code_kept_d | next_sel;
                            idx_q   <= idx_q - 1'b1;
                            state_q <= TEST_STATE;
                            cnt_q   <= SETTLE_LOAD;
                        end else begin
                            code_q   <= code_kept_d;
                            result_q <= code_kept_d;
                            busy_q   <= 1'b0;
                            done_q   <= 1'b1;
                            state_q  <= DONE;
                        end
                    end
                    DONE:    state_q <= IDLE;
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    bin2therm #(.BIN_W(WIDTH)) u_therm (
        .bin_i   (code_q),
        .therm_o (dac_therm)
    );

    assign sample   = sample_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign dac_code = code_q;
    assign result   = result_q;

endmodule

// File: tb/tb_sar_ctrl.sv
// Directed bench for sar_ctrl: table-driven conversions plus abort, reset,
// back-to-back start and zero-settle sequences.
module tb_sar_ctrl;

    logic        clk = 1'b0;
    logic        rst, start, abort;
    logic [4:0]  vin;
    logic        comp_in, sample, busy, done;
    logic [3:0]  dac_code, result;
    logic [14:0] dac_therm;

    logic        start0, abort0;
    logic [4:0]  vin0;
    logic        comp0, sample0, busy0, done0;
    logic [3:0]  code0, result0;
    logic [14:0] therm0;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    // Behavioural comparator: 1 when vin is at or above the DAC level.
    assign comp_in = ({1'b0, vin} >= {2'b00, dac_code});
    assign comp0   = ({1'b0, vin0} >= {2'b00, code0});

    sar_ctrl #(.WIDTH(4), .SAMPLE_CYCLES(2), .SETTLE_CYCLES(1)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .comp_in(comp_in),
        .sample(sample), .dac_code(dac_code), .dac_therm(dac_therm),
        .busy(busy), .done(done), .result(result)
    );

    sar_ctrl #(.WIDTH(4), .SAMPLE_CYCLES(2), .SETTLE_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .abort(abort0), .comp_in(comp0),
        .sample(sample0), .dac_code(code0), .dac_therm(therm0),
        .busy(busy0), .done(done0), .result(result0)
    );

    typedef struct {
        logic [4:0]  vin;
        logic [15:0] codes;   // trial codes for bits 3,2,1,0, first in [15:12]
        logic [3:0]  res;
        logic [14:0] therm;   // dac_therm expected in the DONE cycle
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [14:0] therm_of(input logic [3:0] c);
        logic [14:0] t;
        t = '0;
        for (int k = 0; k < 15; k++) t[k] = (int'(c) > k);
        return t;
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Checks cycles first_c..11 of a default conversion; returns at cycle 11.
    task automatic check_conv(input int first_c, input logic [15:0] codes,
                              input logic [3:0] res, input logic [14:0] therm);
        logic [3:0] ec;
        for (int c = first_c; c <= 11; c++) begin
            if (c != 1) tick();
            if (c <= 2) begin
                check("sample_phase", {sample, busy, done, dac_code}, {3'b110, 4'h0});
            end else if (c <= 10) begin
                ec = codes[15 - 4 * ((c - 3) / 2) -: 4];
                check("trial_code", {sample, busy, done, dac_code}, {3'b010, ec});
                check("therm_trial", dac_therm, therm_of(ec));
            end else begin
                check("done_cycle", {sample, busy, done, dac_code}, {3'b001, res});
                check("result", result, res);
                check("therm_done", dac_therm, therm);
            end
        end
    endtask

    task automatic run_conv(input vec_t v);
        vin   = v.vin;
        start = 1'b1;
        tick();
        start = 1'b0;
        check_conv(1, v.codes, v.res, v.therm);
        tick();
        check("idle_after", {sample, busy, done}, 3'b000);
        check("result_held", result, v.res);
    endtask

    initial begin
        vecs[0] = '{vin: 5'd15, codes: 16'h8CEF, res: 4'hF, therm: 15'h7FFF};
        vecs[1] = '{vin: 5'd0,  codes: 16'h8421, res: 4'h0, therm: 15'h0000};
        vecs[2] = '{vin: 5'd10, codes: 16'h8CAB, res: 4'hA, therm: 15'b000001111111111};
        vecs[3] = '{vin: 5'd5,  codes: 16'h8465, res: 4'h5, therm: 15'h001F};
        vecs[4] = '{vin: 5'd7,  codes: 16'h8467, res: 4'h7, therm: 15'h007F};

        rst = 1'b1; start = 1'b0; abort = 1'b0; vin = '0;
        start0 = 1'b0; abort0 = 1'b0; vin0 = '0;
        @(negedge clk);
        tick();
        check("reset_outs", {sample, busy, done, dac_code, result}, 11'h0);
        check("reset_therm", dac_therm, 15'h0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 5; i++) run_conv(vecs[i]);

        // abort during cycle 6 (compare of bit 2); previous result is 7
        vin = 5'd5; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_idle", {sample, busy, done, dac_code}, 7'h0);
        check("abort_result", result, 4'h7);
        for (int c = 0; c < 6; c++) begin
            tick();
            check("abort_no_done", {busy, done}, 2'b00);
        end
        run_conv(vecs[3]);

        // start held high: exactly one IDLE cycle between done and next SAMPLE
        vin = 5'd10; start = 1'b1;
        tick();
        check_conv(1, vecs[2].codes, vecs[2].res, vecs[2].therm);
        tick();
        check("b2b_idle", {sample, busy, done}, 3'b000);
        tick();
        check("b2b_restart", {sample, busy, done}, 3'b110);
        start = 1'b0;
        check_conv(2, vecs[2].codes, vecs[2].res, vecs[2].therm);
        tick();
        check("b2b_stop", {sample, busy, done}, 3'b000);
        tick();
        check("b2b_stays_idle", {sample, busy}, 2'b00);

        // reset in cycle 5 of a conversion
        vin = 5'd15; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        check("pre_reset_busy", busy, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_outs", {sample, busy, done, dac_code, result}, 11'h0);
        check("midrst_therm", dac_therm, 15'h0);
        tick();
        run_conv(vecs[2]);

        // zero settle cycles: compares in cycles 3..6, done in cycle 7
        vin0 = 5'd10; start0 = 1'b1;
        tick();
        start0 = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            if (c != 1) tick();
            if (c <= 2)
                check("s0_sample", {sample0, busy0, done0, code0}, {3'b110, 4'h0});
            else if (c <= 6)
                check("s0_trial", {sample0, busy0, done0, code0},
                      {3'b010, vecs[2].codes[15 - 4 * (c - 3) -: 4]});
            else if (c == 7)
                check("s0_done", {done0, busy0, result0}, {2'b10, 4'hA});
            else
                check("s0_idle", {sample0, busy0, done0}, 3'b000);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
